// File: rtl/sq_alloc_ctrl.sv
// Store-queue allocate/commit/flush driver: packs dispatched stores, shadows SQ head/tail,
// checkpoints tail per branch, and turns ROB retire counts into single-cycle commit pulses.
module sq_alloc_ctrl #(
  parameter  int SQ_DEPTH = 16,
  parameter  int NUM_BR   = 4,
  parameter  int IDX_W    = 7,
  parameter  int NUM_SLOT = 4,
  localparam int PW       = $clog2(SQ_DEPTH),
  localparam int BW       = $clog2(NUM_BR)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SLOT-1:0]                disp_vld,
  input  logic [NUM_SLOT-1:0]                disp_str,
  input  logic [NUM_SLOT-1:0]                disp_br,
  input  logic [NUM_SLOT-1:0][BW-1:0]        disp_br_tag,
  input  logic [NUM_SLOT-1:0][IDX_W-1:0]     disp_rob_idx,
  input  logic                               br_rslv,
  input  logic                               br_mis,
  input  logic [BW-1:0]                      br_tag,
  input  logic [2:0]                         rtr_str_cnt,
  output logic [NUM_SLOT-1:0][IDX_W:0]       indx_str_al,
  output logic                               stll,
  output logic                               flsh,
  output logic [PW-1:0]                      mis_pred_str_ptr,
  output logic                               cmmt_str
);
  localparam int CW = $clog2(NUM_SLOT + 1);
  localparam int SW = $clog2(NUM_SLOT);

  logic [PW:0]                 head, tail, occ;
  logic [PW:0]                 pend;
  logic [PW:0]                 ckpt [NUM_BR];
  logic [NUM_BR-1:0]           ck_vld;
  logic [NUM_SLOT-1:0]         is_st, is_br;
  logic [CW-1:0]               pre [NUM_SLOT+1];
  logic [PW+1:0]               need;
  logic                        stll_int;
  logic [NUM_SLOT-1:0][IDX_W:0] pack;

  assign is_st = disp_vld & disp_str;
  assign is_br = disp_vld & disp_br;

  // pre[k] = number of older stores in the group, i.e. the store's offset from tail
  assign pre[0] = '0;
  for (genvar g = 0; g < NUM_SLOT; g++) begin : g_pre
    assign pre[g+1] = pre[g] + CW'(is_st[g]);
  end

  assign occ      = tail - head;
  assign need     = {1'b0, occ} + (PW+2)'(pre[NUM_SLOT]);
  assign stll_int = (need > (PW+2)'(SQ_DEPTH)) | br_mis;
  assign stll     = rst & stll_int;

  always_comb begin
    pack = '0;
    for (int k = 0; k < NUM_SLOT; k++)
      if (is_st[k]) pack[pre[k][SW-1:0]] = {1'b1, disp_rob_idx[k]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head             <= '0;
      tail             <= '0;
      pend             <= '0;
      ck_vld           <= '0;
      indx_str_al      <= '0;
      flsh             <= 1'b0;
      mis_pred_str_ptr <= '0;
      cmmt_str         <= 1'b0;
      for (int b = 0; b < NUM_BR; b++) ckpt[b] <= '0;
    end else begin
      // retired stores predate any mispredict, so commit runs regardless of flush
      if (pend != '0) begin
        cmmt_str <= 1'b1;
        head     <= head + (PW+1)'(1);
        pend     <= pend + (PW+1)'(rtr_str_cnt) - (PW+1)'(1);
      end else begin
        cmmt_str <= 1'b0;
        pend     <= pend + (PW+1)'(rtr_str_cnt);
      end

      flsh             <= 1'b0;
      mis_pred_str_ptr <= '0;
      indx_str_al      <= '0;
      if (br_mis) begin
        if (ck_vld[br_tag]) begin
          flsh             <= 1'b1;
          mis_pred_str_ptr <= ckpt[br_tag][PW-1:0];
          tail             <= ckpt[br_tag];
          ck_vld           <= '0;
        end
      end else begin
        if (br_rslv) ck_vld[br_tag] <= 1'b0;
        if (!stll_int) begin
          tail        <= tail + (PW+1)'(pre[NUM_SLOT]);
          indx_str_al <= pack;
          for (int k = 0; k < NUM_SLOT; k++)
            if (is_br[k]) begin
              ckpt[disp_br_tag[k]]   <= tail + (PW+1)'(pre[k]);
              ck_vld[disp_br_tag[k]] <= 1'b1;
            end
        end
      end
    end
  end
endmodule

// File: tb/tb_sq_alloc_ctrl.sv
// Bench for sq_alloc_ctrl: directed scenarios plus random traffic against an
// unbounded-counter model of the store queue.
module tb_sq_alloc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  disp_vld, disp_str, disp_br;
  logic [7:0]  disp_br_tag;
  logic [27:0] disp_rob_idx;
  logic        br_rslv, br_mis;
  logic [1:0]  br_tag;
  logic [2:0]  rtr_str_cnt;
  logic [31:0] indx_str_al;
  logic        stll, flsh, cmmt_str;
  logic [3:0]  mis_pred_str_ptr;

  always #5 clk = ~clk;

  sq_alloc_ctrl dut (
    .clk(clk), .rst(rst), .disp_vld(disp_vld), .disp_str(disp_str), .disp_br(disp_br),
    .disp_br_tag(disp_br_tag), .disp_rob_idx(disp_rob_idx), .br_rslv(br_rslv),
    .br_mis(br_mis), .br_tag(br_tag), .rtr_str_cnt(rtr_str_cnt), .indx_str_al(indx_str_al),
    .stll(stll), .flsh(flsh), .mis_pred_str_ptr(mis_pred_str_ptr), .cmmt_str(cmmt_str)
  );

  int n_vec = 0, n_err = 0;
  int cmmt_seen = 0;
  logic st_seen;

  // model: total stores ever allocated / committed, checkpoints as absolute alloc counts
  int m_alloc, m_cmt, m_pend;
  int m_ck [4];
  bit m_ckv [4];
  logic [31:0] e_indx;
  bit e_flsh, e_cmmt;
  int e_ptr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_stll();
    int n = 0;
    if (!rst) return 1'b0;
    for (int k = 0; k < 4; k++) if (disp_vld[k] && disp_str[k]) n++;
    return ((m_alloc - m_cmt + n) > 16) || br_mis;
  endfunction

  task automatic m_step();
    bit stall;
    int j;
    stall = m_stll();
    e_indx = '0; e_flsh = 0; e_cmmt = 0; e_ptr = 0;
    if (!rst) begin
      m_alloc = 0; m_cmt = 0; m_pend = 0;
      for (int t = 0; t < 4; t++) begin m_ckv[t] = 0; m_ck[t] = 0; end
      return;
    end
    if (m_pend > 0) begin e_cmmt = 1; m_cmt++; m_pend--; end
    m_pend += int'(rtr_str_cnt);
    if (br_mis) begin
      if (m_ckv[br_tag]) begin
        e_flsh = 1;
        e_ptr = m_ck[br_tag] % 16;
        m_alloc = m_ck[br_tag];
        for (int t = 0; t < 4; t++) m_ckv[t] = 0;
      end
    end else begin
      if (br_rslv) m_ckv[br_tag] = 0;
      if (!stall) begin
        j = 0;
        for (int k = 0; k < 4; k++) begin
          if (disp_vld[k] && disp_br[k]) begin
            m_ck[disp_br_tag[2*k +: 2]] = m_alloc + j;
            m_ckv[disp_br_tag[2*k +: 2]] = 1;
          end
          if (disp_vld[k] && disp_str[k]) begin
            e_indx[8*j +: 8] = {1'b1, disp_rob_idx[7*k +: 7]};
            j++;
          end
        end
        m_alloc += j;
      end
    end
  endtask

  task automatic cyc();
    #1;
    st_seen = stll;
    chk("stll", 32'(stll), 32'(m_stll()));
    @(posedge clk);
    m_step();
    #1;
    chk("indx_str_al", indx_str_al, e_indx);
    chk("flsh", 32'(flsh), 32'(e_flsh));
    chk("cmmt_str", 32'(cmmt_str), 32'(e_cmmt));
    if (e_flsh) chk("mis_pred_str_ptr", 32'(mis_pred_str_ptr), e_ptr);
    if (cmmt_str === 1'b1) cmmt_seen++;
    @(negedge clk);
  endtask

  task automatic idle();
    disp_vld = '0; disp_str = '0; disp_br = '0; disp_br_tag = '0; disp_rob_idx = '0;
    br_rslv = 0; br_mis = 0; br_tag = '0; rtr_str_cnt = '0;
  endtask

  task automatic disp(input logic [3:0] v, input logic [3:0] s, input logic [27:0] idx);
    idle();
    disp_vld = v; disp_str = s; disp_rob_idx = idx;
  endtask

  initial begin
    int lim, lo;
    idle();
    rst = 0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_indx", indx_str_al, 32'h0);
    chk("rst_cmmt", 32'(cmmt_str), 32'h0);
    rst = 1;

    // four stores, then four more
    disp(4'hF, 4'hF, {7'd3, 7'd2, 7'd1, 7'd0}); cyc();
    chk("t1_pack0", indx_str_al, 32'h83828180);
    disp(4'hF, 4'hF, {7'd7, 7'd6, 7'd5, 7'd4}); cyc();
    chk("t1_pack1", indx_str_al, 32'h87868584);
    chk("t1_stll", 32'(st_seen), 32'h0);

    // branch tag 2 in slot 0, stores behind it, then mispredict
    disp(4'hF, 4'hE, {7'd11, 7'd10, 7'd9, 7'd8});
    disp_br = 4'h1; disp_br_tag = 8'b00_00_00_10; cyc();
    idle(); br_mis = 1; br_tag = 2'd2; cyc();
    chk("t3_flsh", 32'(flsh), 32'h1);
    chk("t3_ptr", 32'(mis_pred_str_ptr), 32'h8);
    idle(); cyc();
    chk("t3_flsh_pulse", 32'(flsh), 32'h0);
    disp(4'h1, 4'h1, {21'd0, 7'd20}); cyc();
    chk("t3_after", indx_str_al, 32'h00000094);

    // compaction of sparse stores
    disp(4'hA, 4'hA, {7'd9, 7'd0, 7'd5, 7'd0}); cyc();
    chk("t2_pack", indx_str_al, 32'h00008985);

    // fill to 16 then overflow
    disp(4'hF, 4'hF, {7'd33, 7'd32, 7'd31, 7'd30}); cyc();
    disp(4'h1, 4'h1, {21'd0, 7'd34}); cyc();
    disp(4'h1, 4'h1, {21'd0, 7'd35}); cyc();
    chk("t4_stll", 32'(st_seen), 32'h1);
    chk("t4_drop", indx_str_al, 32'h0);
    disp(4'h1, 4'h1, {21'd0, 7'd35}); rtr_str_cnt = 3'd1; cyc();
    disp(4'h1, 4'h1, {21'd0, 7'd35}); cyc();
    chk("t4_cmmt", 32'(cmmt_str), 32'h1);
    disp(4'h1, 4'h1, {21'd0, 7'd35}); cyc();
    chk("t4_retry", 32'(st_seen), 32'h0);
    chk("t4_retry_pack", indx_str_al, 32'h000000a3);
    disp(4'h2, 4'h2, {14'd0, 7'd36, 7'd0}); cyc();
    chk("t4_full_again", 32'(st_seen), 32'h1);
    idle(); disp_vld = 4'hF; cyc();
    chk("t4_nostore", 32'(st_seen), 32'h0);

    // burst retire
    cmmt_seen = 0;
    idle(); rtr_str_cnt = 3'd4; cyc();
    idle();
    for (int i = 0; i < 6; i++) cyc();
    chk("t5_pulses", 32'(cmmt_seen), 32'd4);

    // mispredict on invalid tag, then reset with pending commits
    idle(); br_mis = 1; br_tag = 2'd1; cyc();
    chk("t6_noflsh", 32'(flsh), 32'h0);
    idle(); rtr_str_cnt = 3'd3; cyc();
    idle(); rst = 0; cyc();
    rst = 1;
    cmmt_seen = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("t6_rst_pend", 32'(cmmt_seen), 32'h0);

    // random traffic
    for (int it = 0; it < 2000; it++) begin
      idle();
      rst = ($urandom_range(0, 199) != 0);
      if (rst) begin
        disp_vld = 4'($urandom);
        disp_str = 4'($urandom | $urandom);
        disp_br = 4'($urandom & $urandom);
        disp_br_tag = 8'($urandom);
        disp_rob_idx = 28'($urandom);
        br_tag = 2'($urandom);
        case ($urandom_range(0, 15))
          0: br_mis = 1;
          1, 2: begin br_rslv = 1; disp_br = '0; end
          default: ;
        endcase
        lo = m_alloc;
        for (int t = 0; t < 4; t++) if (m_ckv[t] && m_ck[t] < lo) lo = m_ck[t];
        lim = lo - m_cmt - m_pend;
        if (lim > 4) lim = 4;
        if (lim < 0) lim = 0;
        if ($urandom_range(0, 2) == 0) rtr_str_cnt = 3'($urandom_range(0, lim));
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
